sd_sector_buffer: RTL

- Core-side initiator for the user_io SD image interface. Serves one 512-byte sector per request for the disk controller (fdc), which issues sector read and write commands against drive A: or B:.
- Holds the sector in an internal dual-port RAM:
  - user_io side fills and drains it through sd_buff_*.
  - fdc side accesses it byte-wise.
- Sits between pcw_core's fdc and user_io on clk_sys.

---
 rtl/sd_sector_buffer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_buffer.sv
`timescale 1ns/1ps
// sd_sector_buffer
// ----------------
// Core-side initiator for the user_io SD image interface. The disk controller
// (fdc) asks for one 512-byte sector at a time to be read into, or written
// out of, an internal 512x8 buffer RAM. The user_io side moves bytes through
// the sd_buff_* signals; the fdc side accesses the buffer byte-wise.
//
// Ports
//   clk_sys, reset_n         clock, asynchronous active-low reset
//   req_lba/req_drive        sector and slot, sampled with req_rd / req_wr
//   req_rd/req_wr            one-cycle request pulses (read wins a tie)
//   busy/done/err            transfer status; done pulses once per request
//   buf_addr/buf_din/buf_we  fdc write port (ignored while busy)
//   buf_dout                 fdc read data, 1-cycle latency
//   img_mounted              mount-change pulses, one per slot
//   sd_lba/sd_rd/sd_wr       request to user_io, one-hot by slot
//   sd_ack                   user_io acknowledge, high for the whole transfer
//   sd_buff_addr/sd_buff_dout/sd_dout_strobe  bytes arriving from the image
//   sd_buff_din              byte to the image, RAM[sd_buff_addr] 1 cycle later
//   dbg_state                current FSM state for observation
//
// Handshake: a request bit (sd_rd/sd_wr) stays high until sd_ack is sampled
// high; it drops the following cycle. The transfer ends when sd_ack is
// sampled low again. A request bit is never raised while an sd_ack left over
// from an aborted transfer is still high.
module sd_sector_buffer #(
    parameter int TIMEOUT_CYCLES = 64000000,
    parameter int DRIVES         = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       req_lba,
    input  logic              req_drive,
    input  logic              req_rd,
    input  logic              req_wr,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [8:0]        buf_addr,
    input  logic [7:0]        buf_din,
    input  logic              buf_we,
    output logic [7:0]        buf_dout,
    input  logic [DRIVES-1:0] img_mounted,
    output logic [31:0]       sd_lba,
    output logic [DRIVES-1:0] sd_rd,
    output logic [DRIVES-1:0] sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_dout_strobe,
    output logic [7:0]        sd_buff_din,
    output logic [1:0]        dbg_state
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // The done pulse is issued in the first IDLE cycle after a transfer ends,
    // so the completion cycle already shows busy=0 and can accept a request.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_REQ = 2'd1,
        ST_WR_REQ = 2'd2,
        ST_XFER   = 2'd3
    } state_t;

    state_t state, state_next;

    // Reset assertion is immediate; release is synchronised to clk_sys.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic [31:0]      lba_q;
    logic             drv_q;
    logic             op_write;
    logic [CNT_W-1:0] cnt;
    logic             busy_q, done_q, err_q;
    logic             stale_ack;
    logic [7:0]       buf_dout_q, sd_buff_din_q;
    logic [7:0]       ram [0:511];

    logic accept_rd, accept_wr, accept, finish, abort, cnt_clear;
    logic timed_out, unmount, ack_live;
    logic ram_sd_we, ram_fdc_we;
    logic [DRIVES-1:0] drv_onehot;

    assign timed_out  = (cnt == CNT_LAST);
    assign unmount    = img_mounted[drv_q];
    // An sd_ack still high from an aborted transfer must not be taken as the
    // acknowledge of a new request.
    assign ack_live   = sd_ack && !stale_ack;
    assign drv_onehot = DRIVES'(1) << drv_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        cnt_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_rd) begin
                    accept_rd  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = ST_RD_REQ;
                end else if (req_wr) begin
                    accept_wr  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = ST_WR_REQ;
                end
            end
            ST_RD_REQ, ST_WR_REQ: begin
                if (unmount || timed_out) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else if (ack_live) begin
                    cnt_clear  = 1'b1;
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (unmount || timed_out) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else if (!sd_ack) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept = accept_rd || accept_wr;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lba_q     <= 32'd0;
            drv_q     <= 1'b0;
            op_write  <= 1'b0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            stale_ack <= 1'b0;
        end else begin
            if (accept) begin
                lba_q    <= req_lba;
                drv_q    <= req_drive;
                op_write <= accept_wr;
            end
            if (cnt_clear)               cnt <= '0;
            else if (state != ST_IDLE)   cnt <= cnt + 1'b1;

            if (accept)                  busy_q <= 1'b1;
            else if (finish || abort)    busy_q <= 1'b0;

            done_q <= finish || abort;

            if (accept)     err_q <= 1'b0;
            else if (abort) err_q <= 1'b1;

            // Any sd_ack seen while idle or left high by an abort is stale
            // until user_io lets it fall.
            stale_ack <= sd_ack && (stale_ack || abort || state == ST_IDLE);
        end
    end

    // The two writers are mutually exclusive: user_io writes only during a
    // read transfer (busy=1), the fdc only while busy=0. One write port
    // therefore suffices.
    assign ram_sd_we  = sd_dout_strobe &&
                        ((state == ST_XFER && !op_write) ||
                         (state == ST_RD_REQ && ack_live));
    assign ram_fdc_we = buf_we && !busy_q;

    always_ff @(posedge clk_sys) begin
        if (ram_sd_we)       ram[sd_buff_addr] <= sd_buff_dout;
        else if (ram_fdc_we) ram[buf_addr]     <= buf_din;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            buf_dout_q    <= 8'd0;
            sd_buff_din_q <= 8'd0;
        end else begin
            buf_dout_q    <= ram[buf_addr];
            sd_buff_din_q <= ram[sd_buff_addr];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign buf_dout    = buf_dout_q;
    assign sd_buff_din = sd_buff_din_q;
    assign sd_lba      = lba_q;
    assign sd_rd       = (state == ST_RD_REQ && !stale_ack) ? drv_onehot : '0;
    assign sd_wr       = (state == ST_WR_REQ && !stale_ack) ? drv_onehot : '0;
    assign dbg_state   = state;

endmodule
